// File: rtl/bpu_predictor_pkg.sv
// Shared types and sizing for the fetch-stage branch predictor.
// Latency: n/a (types, constants and index helpers only).
// Backpressure: n/a.
package bpu_predictor_pkg;

   localparam int BTB_ENTRIES  = 64;
   localparam int BHT_ENTRIES  = 64;
   localparam int HIST_W       = 5;

   localparam int BTB_IW       = $clog2(BTB_ENTRIES);
   localparam int BHT_IW       = $clog2(BHT_ENTRIES);
   localparam int LPHT_ENTRIES = 1 << HIST_W;
   localparam int BTB_TAG_W    = 32 - BTB_IW - 3;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // The init sweep must touch every entry of the largest table.
   localparam int INIT_CNT = max3(BTB_ENTRIES, BHT_ENTRIES, LPHT_ENTRIES);
   localparam int INIT_IW  = $clog2(INIT_CNT);

   localparam logic [1:0] LPHT_INIT = 2'b01;

   typedef enum logic {BPU_INIT, BPU_RUN} bpu_state_e;

   typedef struct packed {
      logic              taken;
      logic              fsc;
      logic [31:0]       npc;
      logic [HIST_W-1:0] lphr;
      logic [BHT_IW-1:0] lphr_index;
   } bpu_predict_t;

   typedef struct packed {
      logic [31:0]       pc;
      logic              btb_update;
      logic              lpht_update;
      logic              bht_update;
      logic              br_taken;
      logic [31:0]       br_target;
      logic [1:0]        br_type;
      logic              flush;
      logic [HIST_W-1:0] lphr;
      logic [BHT_IW-1:0] lphr_index;
   } bpu_update_t;

   typedef struct packed {
      logic                 valid;
      logic [BTB_TAG_W-1:0] tag;
      logic                 slot;
      logic [31:0]          target;
   } bpu_btb_entry_t;

endpackage

// File: rtl/bpu_predictor_if.sv
// Lookup/training bundle between fetch, the fixer/backend trainers and the predictor.
// Ports: pc_i, pc_valid_i, stall_i, update_i toward the predictor; ready_o, predict_o back.
// Backpressure: stall_i freezes predict_o; ready_o low means lookups and updates are ignored.
interface bpu_predictor_if;
   import bpu_predictor_pkg::*;

   logic [31:0]  pc_i;
   logic         pc_valid_i;
   logic         stall_i;
   bpu_update_t  update_i;
   logic         ready_o;
   bpu_predict_t predict_o;

   modport master (output pc_i, output pc_valid_i, output stall_i, output update_i,
                   input  ready_o, input predict_o);
   modport slave  (input  pc_i, input  pc_valid_i, input  stall_i, input  update_i,
                   output ready_o, output predict_o);
endinterface

// File: rtl/bpu_sat_cnt2.sv
// 2-bit saturating counter next-state function (shared with the backend trainer).
// Latency: combinational; ports cnt_i (current), taken_i (direction), cnt_o (next).
// Backpressure: none.
module bpu_sat_cnt2 (
   input  logic [1:0] cnt_i,
   input  logic       taken_i,
   output logic [1:0] cnt_o
);
   always_comb begin
      cnt_o = cnt_i;
      if (taken_i && (cnt_i != 2'b11)) begin
         cnt_o = cnt_i + 2'd1;
      end else if (!taken_i && (cnt_i != 2'b00)) begin
         cnt_o = cnt_i - 2'd1;
      end
   end
endmodule

// File: rtl/bpu_predictor.sv
// Fetch-stage predictor: tagged BTB + local history + 2-bit pattern table, trained by updates.
// Latency: 1 cycle pc_i -> predict_o; ports clk, rst_n, bus (slave modport of bpu_predictor_if).
// Backpressure: stall_i holds predict_o; ready_o stays low during the table-init sweep.
// Option: define BPU_BYPASS_EN to forward same-cycle updates into the lookup.
module bpu_predictor
   import bpu_predictor_pkg::*;
(
   input logic           clk,
   input logic           rst_n,
   bpu_predictor_if.slave bus
);
   localparam logic [INIT_IW-1:0] INIT_LAST = INIT_IW'(INIT_CNT - 1);

   bpu_state_e          state_q, state_d;
   logic [INIT_IW-1:0]  init_idx_q, init_idx_d;
   logic                init_en, run_en;

   bpu_btb_entry_t      btb_q  [BTB_ENTRIES];
   logic [HIST_W-1:0]   bht_q  [BHT_ENTRIES];
   logic [1:0]          lpht_q [LPHT_ENTRIES];
   bpu_predict_t        predict_q, predict_d;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= BPU_INIT;
         init_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         init_idx_q <= init_idx_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d    = state_q;
      init_idx_d = init_idx_q;
      case (state_q)
         BPU_INIT: begin
            init_idx_d = init_idx_q + 1'b1;
            if (init_idx_q == INIT_LAST) state_d = BPU_RUN;
         end
         BPU_RUN:  state_d = BPU_RUN;
         default:  state_d = BPU_INIT;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      init_en = (state_q == BPU_INIT);
      run_en  = (state_q == BPU_RUN);
   end

   assign bus.ready_o = run_en;

   // ---------------- training path ----------------
   bpu_update_t          upd;
   logic [BTB_IW-1:0]    upd_btb_idx;
   logic [BTB_TAG_W-1:0] upd_tag;
   logic [HIST_W-1:0]    upd_lpht_idx;
   logic                 btb_we, bht_we, lpht_we;
   bpu_btb_entry_t       btb_wdat_d;
   logic [HIST_W-1:0]    bht_wdat_d;
   logic [1:0]           lpht_wdat_d;

   assign upd          = bus.update_i;
   assign upd_btb_idx  = upd.pc[BTB_IW+2:3];
   assign upd_tag      = upd.pc[31:BTB_IW+3];
   assign upd_lpht_idx = upd.lphr ^ upd.pc[HIST_W+2:3];

   bpu_sat_cnt2 u_upd_cnt (
      .cnt_i   (lpht_q[upd_lpht_idx]),
      .taken_i (upd.br_taken),
      .cnt_o   (lpht_wdat_d)
   );

   always_comb begin
      btb_wdat_d = btb_q[upd_btb_idx];
      btb_we     = 1'b0;
      if (run_en && rst_n && upd.btb_update) begin
         if (upd.br_taken) begin
            btb_we     = 1'b1;
            btb_wdat_d = '{valid: 1'b1, tag: upd_tag, slot: upd.pc[2], target: upd.br_target};
         end else if (btb_q[upd_btb_idx].tag == upd_tag) begin
            // A not-taken correction only invalidates the entry that actually aliased.
            btb_we           = 1'b1;
            btb_wdat_d.valid = 1'b0;
         end
      end
      bht_we     = run_en && rst_n && upd.bht_update;
      bht_wdat_d = {upd.lphr[HIST_W-2:0], upd.br_taken};
      lpht_we    = run_en && rst_n && upd.lpht_update;
   end

   // Tables are cleared by the init sweep rather than by rst_n directly.
   always_ff @(posedge clk) begin
      if (init_en) begin
         btb_q[init_idx_q[BTB_IW-1:0]]  <= '0;
         bht_q[init_idx_q[BHT_IW-1:0]]  <= '0;
         lpht_q[init_idx_q[HIST_W-1:0]] <= LPHT_INIT;
      end else begin
         if (btb_we)  btb_q[upd_btb_idx]       <= btb_wdat_d;
         if (bht_we)  bht_q[upd.lphr_index]    <= bht_wdat_d;
         if (lpht_we) lpht_q[upd_lpht_idx]     <= lpht_wdat_d;
      end
   end

   // ---------------- lookup path ----------------
   logic [BTB_IW-1:0]    lk_btb_idx;
   logic [BTB_TAG_W-1:0] lk_tag;
   logic [BHT_IW-1:0]    lk_bht_idx;
   logic [HIST_W-1:0]    lk_lpht_idx;
   bpu_btb_entry_t       btb_rd;
   logic [HIST_W-1:0]    bht_rd;
   logic [1:0]           cnt_rd;
   logic                 lk_taken;

   assign lk_btb_idx = bus.pc_i[BTB_IW+2:3];
   assign lk_tag     = bus.pc_i[31:BTB_IW+3];
   assign lk_bht_idx = bus.pc_i[BHT_IW+2:3];

   always_comb begin
      btb_rd = btb_q[lk_btb_idx];
      bht_rd = bht_q[lk_bht_idx];
`ifdef BPU_BYPASS_EN
      if (btb_we && (upd_btb_idx == lk_btb_idx))      btb_rd = btb_wdat_d;
      if (bht_we && (upd.lphr_index == lk_bht_idx))   bht_rd = bht_wdat_d;
`endif
      // The (possibly forwarded) history selects the pattern counter.
      lk_lpht_idx = bht_rd ^ bus.pc_i[HIST_W+2:3];
      cnt_rd      = lpht_q[lk_lpht_idx];
`ifdef BPU_BYPASS_EN
      if (lpht_we && (upd_lpht_idx == lk_lpht_idx))   cnt_rd = lpht_wdat_d;
`endif
      // A branch in slot 0 is behind the fetch start when the group begins at slot 1.
      lk_taken = btb_rd.valid && (btb_rd.tag == lk_tag)
                 && (btb_rd.slot >= bus.pc_i[2]) && cnt_rd[1];
   end

   always_comb begin
      predict_d = predict_q;
      if (init_en) begin
         predict_d = '0;
      end else if (!bus.stall_i) begin
         if (bus.pc_valid_i) begin
            predict_d.taken      = lk_taken;
            predict_d.fsc        = btb_rd.slot;
            predict_d.npc        = lk_taken ? btb_rd.target
                                            : {bus.pc_i[31:3] + 29'd1, 3'b000};
            predict_d.lphr       = bht_rd;
            predict_d.lphr_index = lk_bht_idx;
         end else begin
            predict_d.taken = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) predict_q <= '0;
      else        predict_q <= predict_d;
   end

   assign bus.predict_o = predict_q;

   logic unused_bits;
   assign unused_bits = ^{bus.pc_i[1:0], upd.pc[1:0], upd.br_type, upd.flush};

endmodule

// File: tb/tb_bpu_predictor.sv
module tb_bpu_predictor;
   import bpu_predictor_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bpu_predictor_if bus();

   bpu_predictor dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc++;

   // mode 0: taken only, 1: full predict, 2: ready only, 3: ready + full predict
   typedef struct packed {
      logic [31:0]  at;
      logic [1:0]   mode;
      logic         rdy;
      bpu_predict_t p;
   } exp_t;

   exp_t  exp_q[$];
   string nm_q[$];
   int    total = 0;
   int    bad   = 0;

   function automatic bpu_predict_t mk(input bit t, input bit f, input logic [31:0] npc,
                                       input int lphr, input int idx);
      bpu_predict_t p;
      p.taken      = t;
      p.fsc        = f;
      p.npc        = npc;
      p.lphr       = HIST_W'(lphr);
      p.lphr_index = BHT_IW'(idx);
      return p;
   endfunction

   task automatic push(input int at, input logic [1:0] mode, input logic rdy,
                       input bpu_predict_t p, input string nm);
      exp_t e;
      e.at = 32'(at); e.mode = mode; e.rdy = rdy; e.p = p;
      exp_q.push_back(e);
      nm_q.push_back(nm);
   endtask

   // Monitor: compares whatever the DUT presents against due expectations.
   exp_t  m_e;
   string m_n;
   always @(negedge clk) begin
      while (exp_q.size() > 0 && int'(exp_q[0].at) <= cyc) begin
         m_e = exp_q.pop_front();
         m_n = nm_q.pop_front();
         total++;
         if (int'(m_e.at) != cyc) begin
            bad++;
            $display("FAIL %s: check for cycle %0d missed (now %0d)", m_n, m_e.at, cyc);
         end else if (m_e.mode == 2'd0) begin
            if (bus.predict_o.taken !== m_e.p.taken) begin
               bad++;
               $display("FAIL %s: taken got %b want %b", m_n, bus.predict_o.taken, m_e.p.taken);
            end
         end else if (m_e.mode == 2'd2) begin
            if (bus.ready_o !== m_e.rdy) begin
               bad++;
               $display("FAIL %s @%0d: ready got %b want %b", m_n, cyc, bus.ready_o, m_e.rdy);
            end
         end else begin
            if (bus.predict_o !== m_e.p || (m_e.mode == 2'd3 && bus.ready_o !== m_e.rdy)) begin
               bad++;
               $display("FAIL %s: got t=%b f=%b npc=%h lphr=%h idx=%0d rdy=%b want t=%b f=%b npc=%h lphr=%h idx=%0d",
                        m_n, bus.predict_o.taken, bus.predict_o.fsc, bus.predict_o.npc,
                        bus.predict_o.lphr, bus.predict_o.lphr_index, bus.ready_o,
                        m_e.p.taken, m_e.p.fsc, m_e.p.npc, m_e.p.lphr, m_e.p.lphr_index);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      bus.pc_i       = '0;
      bus.pc_valid_i = 1'b0;
      bus.stall_i    = 1'b0;
      bus.update_i   = '0;
   endtask

   task automatic set_upd(input logic [31:0] pc, input bit b, input bit l, input bit h,
                          input bit tkn, input logic [31:0] tgt, input int lphr, input int idx);
      bus.update_i.pc          = pc;
      bus.update_i.btb_update  = b;
      bus.update_i.lpht_update = l;
      bus.update_i.bht_update  = h;
      bus.update_i.br_taken    = tkn;
      bus.update_i.br_target   = tgt;
      bus.update_i.lphr        = HIST_W'(lphr);
      bus.update_i.lphr_index  = BHT_IW'(idx);
   endtask

   task automatic upd(input logic [31:0] pc, input bit b, input bit l, input bit h,
                      input bit tkn, input logic [31:0] tgt, input int lphr, input int idx);
      set_idle();
      set_upd(pc, b, l, h, tkn, tgt, lphr, idx);
      tick();
   endtask

   task automatic lookup(input logic [31:0] pc, input bit t, input bit f, input logic [31:0] npc,
                         input int lphr, input int idx, input string nm);
      set_idle();
      bus.pc_i       = pc;
      bus.pc_valid_i = 1'b1;
      push(cyc + 1, 2'd1, 1'b0, mk(t, f, npc, lphr, idx), nm);
      tick();
   endtask

   task automatic stall_cyc(input logic [31:0] pc, input bpu_predict_t p);
      set_idle();
      bus.pc_i       = pc;
      bus.pc_valid_i = 1'b1;
      bus.stall_i    = 1'b1;
      push(cyc + 1, 2'd1, 1'b0, p, "stall_hold");
      tick();
   endtask

   // Reset for one cycle, then expect exactly 64 not-ready cycles and ready afterwards.
   task automatic do_reset(input bit inject);
      int r;
      set_idle();
      rst_n = 1'b0;
      tick();
      r = cyc;
      push(r, 2'd3, 1'b0, '0, "reset_state");
      for (int i = 0; i < 64; i++) push(r + i, 2'd2, 1'b0, '0, "init_not_ready");
      push(r + 64, 2'd2, 1'b1, '0, "ready_rise");
      rst_n = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if (inject && i == 40) upd(32'h1C00_0000, 1, 1, 1, 1, 32'h1C00_0300, 0, 0);
         else begin
            set_idle();
            tick();
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks pending", exp_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      set_idle();
      do_reset(1'b0);

      // 1: cold lookup
      lookup(32'h1C00_0000, 0, 0, 32'h1C00_0008, 0, 0, "first_lookup");

      // 2: train slot-1 branch; history moves so the first lookup is still not taken
      upd(32'h1C00_0004, 1, 1, 1, 1, 32'h1C00_0100, 0, 0);
      lookup(32'h1C00_0004, 0, 1, 32'h1C00_0008, 1, 0, "hist_moved");
      // counter at index 1: 01 -> 10 -> 11 -> 11 (saturates)
      repeat (3) upd(32'h1C00_0004, 0, 1, 0, 1, 32'h0, 1, 0);
      lookup(32'h1C00_0004, 1, 1, 32'h1C00_0100, 1, 0, "trained_taken");

      // 3: retrain the same entry as slot 0
      upd(32'h1C00_0000, 1, 0, 0, 1, 32'h1C00_0100, 0, 0);
      lookup(32'h1C00_0004, 0, 0, 32'h1C00_0008, 1, 0, "slot_behind_start");
      lookup(32'h1C00_0000, 1, 0, 32'h1C00_0100, 1, 0, "slot0_hit");

      // 4: not-taken correction with a different tag leaves the entry alone
      upd(32'h2C00_0000, 1, 0, 0, 0, 32'h0, 0, 0);
      lookup(32'h1C00_0000, 1, 0, 32'h1C00_0100, 1, 0, "tag_miss_keeps");

      // 5: stall holds the taken prediction while pc_i moves
      stall_cyc(32'h1C00_0010, mk(1, 0, 32'h1C00_0100, 1, 0));
      stall_cyc(32'h1C00_0004, mk(1, 0, 32'h1C00_0100, 1, 0));
      stall_cyc(32'hFFFF_FFF8, mk(1, 0, 32'h1C00_0100, 1, 0));
      set_idle();
      push(cyc + 1, 2'd0, 1'b0, mk(0, 0, 32'h0, 0, 0), "no_valid_not_taken");
      tick();

      // 4b: matching-tag correction invalidates
      upd(32'h1C00_0000, 1, 0, 0, 0, 32'h0, 0, 0);
      lookup(32'h1C00_0000, 0, 0, 32'h1C00_0008, 1, 0, "tag_match_clears");

      // 5b: sequential npc wraps; another index
      lookup(32'hFFFF_FFF8, 0, 0, 32'h0000_0000, 0, 63, "npc_wrap");
      lookup(32'h1C00_0010, 0, 0, 32'h1C00_0018, 0, 2, "seq_npc");

      // 6: same-cycle update and lookup of BTB entry 0
      set_idle();
      set_upd(32'h1C00_0000, 1, 0, 0, 1, 32'h1C00_0200, 0, 0);
      bus.pc_i       = 32'h1C00_0000;
      bus.pc_valid_i = 1'b1;
`ifdef BPU_BYPASS_EN
      push(cyc + 1, 2'd1, 1'b0, mk(1, 0, 32'h1C00_0200, 1, 0), "same_cycle_fwd");
`else
      push(cyc + 1, 2'd1, 1'b0, mk(0, 0, 32'h1C00_0008, 1, 0), "same_cycle_old");
`endif
      tick();
      lookup(32'h1C00_0000, 1, 0, 32'h1C00_0200, 1, 0, "after_same_cycle");

      // 6b: reset mid-run clears training; updates during init are dropped
      do_reset(1'b1);
      lookup(32'h1C00_0000, 0, 0, 32'h1C00_0008, 0, 0, "cleared_after_reset");
      lookup(32'h1C00_0004, 0, 0, 32'h1C00_0008, 0, 0, "cleared_slot1");

      set_idle();
      repeat (3) tick();
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d checks never reached, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
